// File: rtl/sdp_hls_pkg.sv
// Shared widths, saturation limits, mode encoding and S1 payload for the SDP X-path stages.
package sdp_hls_pkg;

  localparam int unsigned DATA_WIDTH   = 32;
  localparam int unsigned OP_WIDTH     = 16;
  localparam int unsigned SHIFT_WIDTH  = 6;
  localparam int unsigned PROD_WIDTH   = DATA_WIDTH + OP_WIDTH;
  localparam int unsigned SH_IDX_WIDTH = 5;
  localparam int unsigned CNT_WIDTH    = 32;

  localparam logic [SH_IDX_WIDTH-1:0] SHIFT_MAX = SH_IDX_WIDTH'(31);
  localparam logic [DATA_WIDTH-1:0]   MAX_POS   = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0]   MIN_NEG   = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {BYPASS, MUL, PRELU} mode_e;

  typedef struct packed {
    mode_e                   mode;
    logic                    neg;
    logic [SH_IDX_WIDTH-1:0] shift;
    logic [DATA_WIDTH-1:0]   data;
    logic [PROD_WIDTH-1:0]   prod;
  } s1_pld_t;

  // Shift amounts beyond the legal range behave as the largest legal shift.
  function automatic logic [SH_IDX_WIDTH-1:0] clamp_shift(input logic [SHIFT_WIDTH-1:0] sh);
    return (sh > SHIFT_WIDTH'(SHIFT_MAX)) ? SHIFT_MAX : sh[SH_IDX_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/sdp_hls_x_mul_shift_if.sv
// Valid/ready element channel used on both sides of the multiply/shift stage.
interface sdp_hls_x_mul_shift_if;
  import sdp_hls_pkg::*;

  logic                  pvld;
  logic                  prdy;
  logic [DATA_WIDTH-1:0] data;

  modport master (output pvld, output data, input  prdy);
  modport slave  (input  pvld, input  data, output prdy);

endinterface

// File: rtl/sdp_hls_shift_rnd_sat.sv
// Combinational arithmetic right shift of the full product, round half up, saturate to DATA_WIDTH.
module sdp_hls_shift_rnd_sat
  import sdp_hls_pkg::*;
(
  input  logic [PROD_WIDTH-1:0]   prod_i,
  input  logic [SH_IDX_WIDTH-1:0] shift_i,
  output logic [DATA_WIDTH-1:0]   data_c_o,
  output logic                    sat_c_o
);

  localparam int unsigned SUM_WIDTH = PROD_WIDTH + 1;
  localparam int unsigned IDX_WIDTH = $clog2(PROD_WIDTH);

  logic signed [PROD_WIDTH-1:0] shifted;
  logic [IDX_WIDTH-1:0]         rnd_idx;
  logic                         rnd_bit;
  logic [SUM_WIDTH-1:0]         sum;
  logic                         in_range;

  // One extra bit on the rounding add keeps the carry from wrapping the sign.
  always_comb begin
    shifted  = $signed(prod_i) >>> shift_i;
    rnd_idx  = IDX_WIDTH'(shift_i) - IDX_WIDTH'(1);
    rnd_bit  = (shift_i != '0) ? prod_i[rnd_idx] : 1'b0;
    sum      = {shifted[PROD_WIDTH-1], shifted} + SUM_WIDTH'(rnd_bit);
    in_range = (sum[SUM_WIDTH-1:DATA_WIDTH-1] == '0) || (&sum[SUM_WIDTH-1:DATA_WIDTH-1]);
    sat_c_o  = !in_range;
    if (in_range) begin
      data_c_o = sum[DATA_WIDTH-1:0];
    end else if (sum[SUM_WIDTH-1]) begin
      data_c_o = MIN_NEG;
    end else begin
      data_c_o = MAX_POS;
    end
  end

endmodule

// File: rtl/sdp_hls_x_mul_shift.sv
// Two-stage multiply / shift-round / saturate pipe of the SDP X-path with a saturation counter.
module sdp_hls_x_mul_shift
  import sdp_hls_pkg::*;
(
  input  logic                   nvdla_core_clk,
  input  logic                   nvdla_core_rstn,
  sdp_hls_x_mul_shift_if.slave   chn_in,
  sdp_hls_x_mul_shift_if.master  chn_out,
  input  logic                   cfg_mul_bypass,
  input  logic                   cfg_mul_prelu,
  input  logic [OP_WIDTH-1:0]    cfg_mul_op,
  input  logic [SHIFT_WIDTH-1:0] cfg_mul_shift,
  input  logic                   sat_cnt_clr,
  output logic [CNT_WIDTH-1:0]   sat_cnt
);

  logic                  s1_vld_q, s1_vld_d;
  s1_pld_t               s1_q, s1_d;
  logic                  s2_vld_q, s2_vld_d;
  logic [DATA_WIDTH-1:0] s2_data_q, s2_data_d;
  logic                  s2_sat_q, s2_sat_d;
  logic [CNT_WIDTH-1:0]  sat_cnt_q, sat_cnt_d;

  logic s2_rdy, s1_rdy, in_acc, s1_to_s2, out_acc;
  logic signed [DATA_WIDTH-1:0] din_s;
  logic signed [OP_WIDTH-1:0]   op_s;
  logic [DATA_WIDTH-1:0]        rnd_data;
  logic                         rnd_sat;

  sdp_hls_shift_rnd_sat u_shift_rnd_sat (
    .prod_i   (s1_q.prod),
    .shift_i  (s1_q.shift),
    .data_c_o (rnd_data),
    .sat_c_o  (rnd_sat)
  );

  always_comb begin
    s2_rdy   = !s2_vld_q || chn_out.prdy;
    s1_rdy   = !s1_vld_q || s2_rdy;
    in_acc   = chn_in.pvld && s1_rdy;
    s1_to_s2 = s1_vld_q && s2_rdy;
    out_acc  = s2_vld_q && chn_out.prdy;
    din_s    = $signed(chn_in.data);
    op_s     = $signed(cfg_mul_op);
  end

  // Next-state for both pipe stages and the counter; config travels with each element.
  always_comb begin
    s1_vld_d  = s1_vld_q;
    s1_d      = s1_q;
    s2_vld_d  = s2_vld_q;
    s2_data_d = s2_data_q;
    s2_sat_d  = s2_sat_q;
    sat_cnt_d = sat_cnt_q;

    if (s1_rdy) s1_vld_d = chn_in.pvld;
    if (in_acc) begin
      s1_d.mode  = cfg_mul_bypass ? BYPASS : (cfg_mul_prelu ? PRELU : MUL);
      s1_d.neg   = chn_in.data[DATA_WIDTH-1];
      s1_d.shift = clamp_shift(cfg_mul_shift);
      s1_d.data  = chn_in.data;
      s1_d.prod  = PROD_WIDTH'(PROD_WIDTH'(din_s) * PROD_WIDTH'(op_s));
    end

    if (s2_rdy) s2_vld_d = s1_vld_q;
    if (s1_to_s2) begin
      unique case (s1_q.mode)
        BYPASS: begin
          s2_data_d = s1_q.data;
          s2_sat_d  = 1'b0;
        end
        PRELU: begin
          s2_data_d = s1_q.neg ? rnd_data : s1_q.data;
          s2_sat_d  = s1_q.neg ? rnd_sat  : 1'b0;
        end
        default: begin
          s2_data_d = rnd_data;
          s2_sat_d  = rnd_sat;
        end
      endcase
    end

    if (sat_cnt_clr) begin
      sat_cnt_d = '0;
    end else if (out_acc && s2_sat_q && !(&sat_cnt_q)) begin
      sat_cnt_d = sat_cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (!nvdla_core_rstn) begin
      s1_vld_q  <= 1'b0;
      s1_q      <= '0;
      s2_vld_q  <= 1'b0;
      s2_data_q <= '0;
      s2_sat_q  <= 1'b0;
      sat_cnt_q <= '0;
    end else begin
      s1_vld_q  <= s1_vld_d;
      s1_q      <= s1_d;
      s2_vld_q  <= s2_vld_d;
      s2_data_q <= s2_data_d;
      s2_sat_q  <= s2_sat_d;
      sat_cnt_q <= sat_cnt_d;
    end
  end

  assign chn_in.prdy  = s1_rdy;
  assign chn_out.pvld = s2_vld_q;
  assign chn_out.data = s2_data_q;
  assign sat_cnt      = sat_cnt_q;

endmodule

// File: tb/tb_sdp_hls_x_mul_shift.sv
// Bench for sdp_hls_x_mul_shift: arithmetic reference model plus directed vectors.
module tb_sdp_hls_x_mul_shift;

  logic        clk = 1'b0;
  logic        rstn;
  logic        cfg_bypass, cfg_prelu, clr;
  logic [15:0] cfg_op;
  logic [5:0]  cfg_shift;
  logic [31:0] sat_cnt;

  sdp_hls_x_mul_shift_if in_if ();
  sdp_hls_x_mul_shift_if out_if ();

  sdp_hls_x_mul_shift dut (
    .nvdla_core_clk  (clk),
    .nvdla_core_rstn (rstn),
    .chn_in          (in_if),
    .chn_out         (out_if),
    .cfg_mul_bypass  (cfg_bypass),
    .cfg_mul_prelu   (cfg_prelu),
    .cfg_mul_op      (cfg_op),
    .cfg_mul_shift   (cfg_shift),
    .sat_cnt_clr     (clr),
    .sat_cnt         (sat_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    bit          sat;
  } exp_t;

  exp_t        expq[$];
  int          n_cmp = 0;
  int          n_fail = 0;
  int          n_out = 0;
  bit          mon_en = 1'b0;
  logic [31:0] model_cnt = 32'd0;
  logic [31:0] last_out = 32'd0;
  logic [31:0] stream_vals[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference: exact product, round half up by adding half an LSB before flooring, then clamp.
  function automatic exp_t model(input logic [31:0] d, input bit byp, input bit pre,
                                 input logic [15:0] op, input logic [5:0] sh);
    exp_t   e;
    longint dv, ov, p, r;
    int     s;
    dv = longint'($signed(d));
    ov = longint'($signed(op));
    e.sat = 1'b0;
    e.data = d;
    if (byp || (pre && dv >= 0)) return e;
    s = (sh > 6'd31) ? 31 : int'(sh);
    p = dv * ov;
    if (s > 0) p = p + (64'sd1 <<< (s - 1));
    r = p >>> s;
    if (r > 64'sd2147483647) begin
      e.data = 32'h7FFF_FFFF;
      e.sat = 1'b1;
    end else if (r < -64'sd2147483648) begin
      e.data = 32'h8000_0000;
      e.sat = 1'b1;
    end else begin
      e.data = r[31:0];
    end
    return e;
  endfunction

  // Compare process: every output beat against the model queue, sat_cnt every cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      check("sat_cnt", sat_cnt, model_cnt);
      if (!rstn) begin
        expq.delete();
        model_cnt = 32'd0;
      end else begin
        if (out_if.pvld && out_if.prdy) begin
          if (expq.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_out: got 0x%08h, expected no output", out_if.data);
          end else begin
            exp_t e;
            e = expq.pop_front();
            check("out_data", out_if.data, e.data);
            if (e.sat && model_cnt != 32'hFFFF_FFFF) model_cnt = model_cnt + 32'd1;
          end
          last_out = out_if.data;
          n_out++;
        end
        if (clr) model_cnt = 32'd0;
        if (in_if.pvld && in_if.prdy)
          expq.push_back(model(in_if.data, cfg_bypass, cfg_prelu, cfg_op, cfg_shift));
      end
    end
  end

  task automatic set_cfg(input bit byp, input bit pre, input logic [15:0] op, input logic [5:0] sh);
    cfg_bypass = byp;
    cfg_prelu  = pre;
    cfg_op     = op;
    cfg_shift  = sh;
  endtask

  // One element with the output always ready; checks the result against a hand-computed literal.
  task automatic drive_one(input logic [31:0] d, input bit byp, input bit pre, input logic [15:0] op,
                           input logic [5:0] sh, input logic [31:0] exp_lit, input string name);
    int start;
    bit got;
    @(posedge clk); #1;
    set_cfg(byp, pre, op, sh);
    in_if.data = d;
    in_if.pvld = 1'b1;
    start = n_out;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_if.prdy) break;
    end
    @(posedge clk); #1;
    in_if.pvld = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      if (n_out != start) begin
        got = 1'b1;
        break;
      end
    end
    check({name, "_arrived"}, 32'(got), 32'd1);
    check(name, last_out, exp_lit);
  endtask

  // Streams n values from stream_vals; output ready held low for the first 'hold' cycles.
  task automatic stream(input int n, input int hold, input int chk_cyc, input int chk_idx);
    int idx = 0;
    int cyc = 0;
    while (idx < n && cyc < 200) begin
      @(posedge clk); #1;
      in_if.pvld  = 1'b1;
      in_if.data  = stream_vals[idx];
      out_if.prdy = (cyc >= hold);
      @(negedge clk);
      if (cyc == chk_cyc) begin
        check("bp_accepted", 32'(idx), 32'(chk_idx));
        check("bp_in_prdy", 32'(in_if.prdy), 32'd0);
      end
      if (in_if.prdy) idx++;
      cyc++;
    end
    check("stream_done", 32'(idx), 32'(n));
    @(posedge clk); #1;
    in_if.pvld = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int start;
    rstn = 1'b0;
    clr = 1'b0;
    in_if.pvld = 1'b0;
    in_if.data = 32'd0;
    out_if.prdy = 1'b1;
    set_cfg(1'b0, 1'b0, 16'd0, 6'd0);

    @(posedge clk); #1;
    mon_en = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_pvld", 32'(out_if.pvld), 32'd0);
    check("rst_out_data", out_if.data, 32'd0);
    check("rst_sat_cnt", sat_cnt, 32'd0);
    @(posedge clk); #1;
    rstn = 1'b1;
    @(negedge clk);
    check("post_rst_in_prdy", 32'(in_if.prdy), 32'd1);

    // Bypass with explicit two-cycle latency check.
    @(posedge clk); #1;
    set_cfg(1'b1, 1'b0, 16'd3, 6'd1);
    in_if.data = 32'h8000_0001;
    in_if.pvld = 1'b1;
    @(posedge clk); #1;
    in_if.pvld = 1'b0;
    @(negedge clk);
    check("lat_cycle1_pvld", 32'(out_if.pvld), 32'd0);
    @(negedge clk);
    check("lat_cycle2_pvld", 32'(out_if.pvld), 32'd1);
    check("bypass_data", out_if.data, 32'h8000_0001);
    @(negedge clk);
    check("bypass_sat_cnt", sat_cnt, 32'd0);

    drive_one(32'd5,         1'b0, 1'b0, 16'd3, 6'd1, 32'd8,         "mul_pos_rnd");
    drive_one(32'hFFFF_FFFB, 1'b0, 1'b0, 16'd3, 6'd1, 32'hFFFF_FFF9, "mul_neg_rnd");
    drive_one(32'h7FFF_FFFF, 1'b0, 1'b0, 16'h7FFF, 6'd0, 32'h7FFF_FFFF, "sat_pos");
    @(negedge clk);
    check("sat_cnt_1", sat_cnt, 32'd1);
    drive_one(32'h8000_0000, 1'b0, 1'b0, 16'h7FFF, 6'd0, 32'h8000_0000, "sat_neg");
    @(negedge clk);
    check("sat_cnt_2", sat_cnt, 32'd2);
    drive_one(32'd100,       1'b0, 1'b1, 16'd1, 6'd3, 32'd100,       "prelu_pos");
    drive_one(32'hFFFF_FFF0, 1'b0, 1'b1, 16'd1, 6'd3, 32'hFFFF_FFFE, "prelu_neg");
    drive_one(32'h4000_0000, 1'b0, 1'b0, 16'd1, 6'd40, 32'd1,        "shift_clamp");
    drive_one(32'hFFFF_FFF0, 1'b1, 1'b1, 16'd3, 6'd0, 32'hFFFF_FFF0, "bypass_over_prelu");
    drive_one(32'hFFFF_FFFF, 1'b0, 1'b0, 16'h8000, 6'd31, 32'd0,     "max_shift_rnd");

    // Back-pressure: output stalled for 5 cycles while 4 elements stream in.
    set_cfg(1'b0, 1'b0, 16'hFFFF, 6'd2);
    stream_vals[0] = 32'd10;
    stream_vals[1] = 32'hFFFF_FF9C;
    stream_vals[2] = 32'd7;
    stream_vals[3] = 32'h1234_5678;
    start = n_out;
    stream(4, 5, 4, 2);
    out_if.prdy = 1'b1;
    for (int i = 0; i < 20 && n_out < start + 4; i++) @(posedge clk);
    @(negedge clk);
    check("bp_out_count", 32'(n_out - start), 32'd4);
    check("bp_queue_empty", 32'(expq.size()), 32'd0);

    // Reset with both stages full discards them and clears the counter.
    set_cfg(1'b0, 1'b0, 16'h7FFF, 6'd0);
    stream_vals[0] = 32'h7FFF_FFFF;
    stream_vals[1] = 32'h8000_0000;
    stream(2, 1000, -1, 0);
    @(negedge clk);
    check("full_out_pvld", 32'(out_if.pvld), 32'd1);
    check("full_in_prdy", 32'(in_if.prdy), 32'd0);
    @(posedge clk); #1;
    rstn = 1'b0;
    @(posedge clk); #1;
    check("rst_full_out_pvld", 32'(out_if.pvld), 32'd0);
    check("rst_full_sat_cnt", sat_cnt, 32'd0);
    rstn = 1'b1;
    out_if.prdy = 1'b1;
    @(negedge clk);
    check("rst_full_in_prdy", 32'(in_if.prdy), 32'd1);

    // Clear coincident with a saturating drain: clear wins.
    drive_one(32'h7FFF_FFFF, 1'b0, 1'b0, 16'h7FFF, 6'd0, 32'h7FFF_FFFF, "sat_before_clr");
    @(negedge clk);
    check("sat_cnt_before_clr", sat_cnt, 32'd1);
    stream_vals[0] = 32'h8000_0000;
    stream(1, 1000, -1, 0);
    @(posedge clk); #1;
    out_if.prdy = 1'b1;
    clr = 1'b1;
    @(negedge clk);
    check("clr_held_pvld", 32'(out_if.pvld), 32'd1);
    @(posedge clk); #1;
    clr = 1'b0;
    @(negedge clk);
    check("clr_wins_sat_cnt", sat_cnt, 32'd0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("final_queue_empty", 32'(expq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
